// File: rtl/cpu_pkg.sv
// cpu_pkg: cont encodings, instruction field slices and sequencer states shared with the condition code unit
package cpu_pkg;
    typedef enum logic [3:0] {
        NOP  = 4'd0,
        JMP  = 4'd1,
        CALL = 4'd2,
        RET  = 4'd3,
        JZ   = 4'd4,
        JNZ  = 4'd5,
        JC   = 4'd6,
        JNC  = 4'd7
    } cont_e;
    localparam int CONT_HI = 15;
    localparam int CONT_LO = 12;
    localparam int OP_HI   = 11;
    localparam int OP_LO   = 8;
    localparam int TGT_HI  = 7;
    localparam int TGT_LO  = 0;
    typedef logic [2:0] state_t;
    localparam state_t FETCH = 3'd0;
    localparam state_t LOAD  = 3'd1;
    localparam state_t EXEC  = 3'd2;
    localparam state_t EVAL  = 3'd3;
    localparam state_t HALT  = 3'd4;
    // JMP plus the 01xx conditional-jump group all branch to the target on tcnd
    function automatic logic is_jump(input logic [3:0] c);
        return c == JMP || c[3:2] == 2'b01;
    endfunction
endpackage

// File: rtl/branch_sequencer_if.sv
// branch_sequencer_if: ROM, condition code and datapath signals of the program sequencer
// master (sequencer): drives rom_addr, cont, ir, exec_en, halt, pc; receives rom_data, tcnd
// slave (environment): the opposite directions
interface branch_sequencer_if #(
    parameter int PC_W = 8,
    parameter int IW   = 16
);
    logic [PC_W-1:0] rom_addr;
    logic [IW-1:0]   rom_data;
    logic [3:0]      cont;
    logic            tcnd;
    logic [IW-1:0]   ir;
    logic            exec_en;
    logic            halt;
    logic [PC_W-1:0] pc;
    modport master (
        output rom_addr, cont, ir, exec_en, halt, pc,
        input  rom_data, tcnd
    );
    modport slave (
        input  rom_addr, cont, ir, exec_en, halt, pc,
        output rom_data, tcnd
    );
endinterface

// File: rtl/ret_stack.sv
// ret_stack: return-address LIFO with push/pop and full/empty flags
// push_i/data_i write the entry at sp; pop_i drops the top; top_o is the entry at sp-1
module ret_stack #(
    parameter int STK_DEPTH = 4,
    parameter int PC_W      = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [PC_W-1:0] data_i,
    output logic [PC_W-1:0] top_o,
    output logic            full_o,
    output logic            empty_o
);
    localparam int AW = $clog2(STK_DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);
    localparam logic [AW:0] FULL = (AW+1)'(STK_DEPTH);
    logic [AW:0]     sp_q, sp_d;
    logic [PC_W-1:0] mem_q [STK_DEPTH];
    always_comb sp_d = push_i ? sp_q + ONE : pop_i ? sp_q - ONE : sp_q;
    assign top_o   = mem_q[AW'(sp_q - ONE)];
    assign full_o  = sp_q == FULL;
    assign empty_o = sp_q == '0;
    always_ff @(posedge clk) begin
        if (rst) sp_q <= '0;
        else sp_q <= sp_d;
    end
    always_ff @(posedge clk) begin
        if (!rst && push_i) mem_q[sp_q[AW-1:0]] <= data_i;
    end
endmodule

// File: rtl/branch_sequencer.sv
// branch_sequencer: PC owner, ROM fetch and next-PC selection (sequential/jump/call/return)
// clk, rst: clock and synchronous active-high reset
// bus (master): rom_addr/rom_data ROM port, cont/tcnd condition unit, ir/exec_en datapath, halt/pc status
module branch_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_W      = 8,
    parameter int IW        = 16,
    parameter int STK_DEPTH = 4
) (
    input logic                clk,
    input logic                rst,
    branch_sequencer_if.master bus
);
    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, pc_inc, tgt, top;
    logic [IW-1:0]   ir_q, ir_d;
    logic [3:0]      cont_q, cont_d;
    logic            halt_q, halt_d, push, pop, full, empty, fault;
    assign pc_inc = pc_q + PC_W'(1);
    assign tgt    = PC_W'(ir_q[TGT_HI:TGT_LO]);
    // faults only arise on a taken CALL/RET; reserved codes fall through as NOP
    assign fault  = state_q == EVAL && bus.tcnd &&
                    ((cont_q == CALL && full) || (cont_q == RET && empty));
    assign push   = state_q == EVAL && bus.tcnd && cont_q == CALL && !full;
    assign pop    = state_q == EVAL && bus.tcnd && cont_q == RET && !empty;
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cont_d  = cont_q;
        halt_d  = halt_q;
        case (state_q)
            FETCH: state_d = LOAD;
            LOAD: begin
                ir_d    = bus.rom_data;
                cont_d  = bus.rom_data[CONT_HI:CONT_LO];
                state_d = EXEC;
            end
            EXEC: state_d = EVAL;
            EVAL: begin
                state_d = fault ? HALT : FETCH;
                halt_d  = fault;
                pc_d    = fault ? pc_q :
                          push || (is_jump(cont_q) && bus.tcnd) ? tgt :
                          pop ? top : pc_inc;
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            cont_q  <= '0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cont_q  <= cont_d;
            halt_q  <= halt_d;
        end
    end
    ret_stack #(.STK_DEPTH(STK_DEPTH), .PC_W(PC_W)) u_stack (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (pc_inc),
        .top_o   (top),
        .full_o  (full),
        .empty_o (empty)
    );
    assign bus.rom_addr = pc_q;
    assign bus.pc       = pc_q;
    assign bus.ir       = ir_q;
    assign bus.cont     = cont_q;
    assign bus.exec_en  = state_q == EXEC;
    assign bus.halt     = halt_q;
endmodule

// File: tb/tb_branch_sequencer.sv
// tb_branch_sequencer: directed checks of fetch timing, jumps, call/return, stack faults and reset
module tb_branch_sequencer;
    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        tcnd = 1'b0;
    logic [15:0] rom [256];
    logic [15:0] rom_q;
    int          checks   = 0;
    int          failures = 0;
    branch_sequencer_if #(.PC_W(8), .IW(16)) bus ();
    branch_sequencer #(.PC_W(8), .IW(16), .STK_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    always #5 clk = ~clk;
    always_ff @(posedge clk) rom_q <= rom[bus.rom_addr];
    assign bus.rom_data = rom_q;
    assign bus.tcnd     = tcnd;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask
    task automatic clear_rom();
        foreach (rom[i]) rom[i] = 16'h0000;
    endtask
    // entered at FETCH; leaves at the next FETCH
    task automatic run_instr(input logic [7:0] addr, input string tag);
        chk({tag, "_addr"}, 32'(bus.rom_addr), 32'(addr));
        tick(2);
        chk({tag, "_exec"}, 32'(bus.exec_en), 32'd1);
        tick(2);
    endtask
    initial begin
        clear_rom();
        do_reset();
        chk("rst_pc", 32'(bus.pc), 32'h00);
        chk("rst_rom_addr", 32'(bus.rom_addr), 32'h00);
        chk("rst_ir", 32'(bus.ir), 32'h0000);
        chk("rst_cont", 32'(bus.cont), 32'h0);
        chk("rst_exec", 32'(bus.exec_en), 32'd0);
        chk("rst_halt", 32'(bus.halt), 32'd0);
        chk("rst_sp", 32'(dut.u_stack.sp_q), 32'd0);
        // NOP stream: exec_en only in the third cycle of each instruction
        for (int i = 0; i < 4; i++) begin
            chk("nop_addr", 32'(bus.rom_addr), 32'(i));
            chk("nop_fetch_exec", 32'(bus.exec_en), 32'd0);
            tick(1);
            chk("nop_load_exec", 32'(bus.exec_en), 32'd0);
            tick(1);
            chk("nop_exec", 32'(bus.exec_en), 32'd1);
            tick(1);
            chk("nop_eval_exec", 32'(bus.exec_en), 32'd0);
            tick(1);
        end
        // taken JMP, then reserved code with tcnd=1 behaves as NOP
        clear_rom();
        rom[8'h00] = 16'h1040;
        rom[8'h40] = 16'hF0AA;
        tcnd = 1'b1;
        do_reset();
        run_instr(8'h00, "jmp");
        chk("jmp_cont", 32'(bus.cont), 32'h1);
        chk("jmp_target", 32'(bus.rom_addr), 32'h40);
        run_instr(8'h40, "rsvd");
        chk("rsvd_ir", 32'(bus.ir), 32'hF0AA);
        chk("rsvd_next", 32'(bus.rom_addr), 32'h41);
        // not-taken JZ
        clear_rom();
        rom[8'h00] = 16'h4040;
        tcnd = 1'b0;
        do_reset();
        run_instr(8'h00, "jz");
        chk("jz_ir", 32'(bus.ir), 32'h4040);
        chk("jz_cont", 32'(bus.cont), 32'h4);
        chk("jz_next", 32'(bus.rom_addr), 32'h01);
        // CALL / RET round trip
        clear_rom();
        rom[8'h05] = 16'h2080;
        rom[8'h80] = 16'h3000;
        tcnd = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) run_instr(8'(i), "pre_call");
        run_instr(8'h05, "call");
        chk("call_sp", 32'(dut.u_stack.sp_q), 32'd1);
        run_instr(8'h80, "ret");
        chk("ret_sp", 32'(dut.u_stack.sp_q), 32'd0);
        run_instr(8'h06, "after_ret");
        // five nested CALLs: the fifth overflows
        clear_rom();
        rom[8'h00] = 16'h2010;
        rom[8'h10] = 16'h2020;
        rom[8'h20] = 16'h2030;
        rom[8'h30] = 16'h2040;
        rom[8'h40] = 16'h2050;
        do_reset();
        run_instr(8'h00, "call1");
        run_instr(8'h10, "call2");
        run_instr(8'h20, "call3");
        run_instr(8'h30, "call4");
        chk("full_sp", 32'(dut.u_stack.sp_q), 32'd4);
        chk("full_halt", 32'(bus.halt), 32'd0);
        run_instr(8'h40, "call5");
        chk("ovf_halt", 32'(bus.halt), 32'd1);
        chk("ovf_pc", 32'(bus.pc), 32'h40);
        chk("ovf_sp", 32'(dut.u_stack.sp_q), 32'd4);
        for (int i = 0; i < 8; i++) begin
            chk("ovf_exec", 32'(bus.exec_en), 32'd0);
            chk("ovf_rom_addr", 32'(bus.rom_addr), 32'h40);
            tick(1);
        end
        chk("ovf_cont_held", 32'(bus.cont), 32'h2);
        chk("ovf_halt_sticky", 32'(bus.halt), 32'd1);
        // RET on empty stack underflows; reset recovers
        clear_rom();
        rom[8'h00] = 16'h3000;
        do_reset();
        run_instr(8'h00, "unf");
        chk("unf_halt", 32'(bus.halt), 32'd1);
        chk("unf_pc", 32'(bus.pc), 32'h00);
        tick(3);
        chk("unf_exec", 32'(bus.exec_en), 32'd0);
        do_reset();
        chk("unf_rst_halt", 32'(bus.halt), 32'd0);
        chk("unf_rst_addr", 32'(bus.rom_addr), 32'h00);
        tick(2);
        chk("unf_rst_exec", 32'(bus.exec_en), 32'd1);
        // PC wrap 0xFF -> 0x00
        clear_rom();
        rom[8'h00] = 16'h10FF;
        do_reset();
        run_instr(8'h00, "to_ff");
        run_instr(8'hFF, "wrap");
        chk("wrap_addr", 32'(bus.rom_addr), 32'h00);
        // reset during EXEC of a taken JMP
        tick(2);
        chk("mid_exec", 32'(bus.exec_en), 32'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mid_pc", 32'(bus.pc), 32'h00);
        chk("mid_ir", 32'(bus.ir), 32'h0000);
        chk("mid_cont", 32'(bus.cont), 32'h0);
        chk("mid_exec_clr", 32'(bus.exec_en), 32'd0);
        tick(3);
        chk("mid_eval_pc", 32'(bus.pc), 32'h00);
        tick(1);
        chk("mid_refetch_jmp", 32'(bus.rom_addr), 32'hFF);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
